// File: rtl/univ_shift_reg_if.sv
// Command/status bundle for univ_shift_reg: the controller drives the master side,
// and the shifter sits on the slave side.
interface univ_shift_reg_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
);
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, serial_in, par_in,
    input  out, serial_out, busy, done
  );

  modport slave (
    input  start, mode, amount, serial_in, par_in,
    output out, serial_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, clear, and logical, rotate or arithmetic
// shifts by a programmable amount. Each shift step takes one clock, with a start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; the command is decoded on the accepting edge
// S_SHIFT | one 1-bit step per edge until r_count reaches zero
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module univ_shift_reg #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input logic              clk,
  input logic              reset,
  univ_shift_reg_if.slave  bus
);

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SLL  = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_NOP  = 3'b111;

  localparam logic [AMT_W-1:0] LP_WIDTH = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] LP_ONE   = AMT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_serial_out;
  logic             r_busy;
  logic             r_done;

  logic [AMT_W-1:0] w_amt_clamped;
  logic [WIDTH-1:0] w_next;
  logic             w_shifted_bit;

  assign w_amt_clamped = (bus.amount >= LP_WIDTH) ? LP_WIDTH : bus.amount;

  // Single-step result for the latched mode; serial_in is used live on each shift edge.
  always_comb begin
    w_next        = r_out;
    w_shifted_bit = r_serial_out;
    case (r_mode)
      MODE_SLL: begin
        w_next        = {r_out[WIDTH-2:0], bus.serial_in};
        w_shifted_bit = r_out[WIDTH-1];
      end
      MODE_SRL: begin
        w_next        = {bus.serial_in, r_out[WIDTH-1:1]};
        w_shifted_bit = r_out[0];
      end
      MODE_ROL: begin
        w_next        = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
        w_shifted_bit = r_out[WIDTH-1];
      end
      MODE_ROR: begin
        w_next        = {r_out[0], r_out[WIDTH-1:1]};
        w_shifted_bit = r_out[0];
      end
      MODE_ASR: begin
        w_next        = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
        w_shifted_bit = r_out[0];
      end
      default: begin
        w_next        = r_out;
        w_shifted_bit = r_serial_out;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mode       <= MODE_NOP;
      r_count      <= '0;
      r_out        <= '0;
      r_serial_out <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            case (bus.mode)
              MODE_LOAD: begin
                r_out   <= bus.par_in;
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              MODE_CLR: begin
                r_out   <= '0;
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              MODE_NOP: begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
              default: begin
                r_mode  <= bus.mode;
                r_count <= w_amt_clamped;
                if (w_amt_clamped == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_SHIFT;
                end
              end
            endcase
          end
        end
        S_SHIFT: begin
          r_out        <= w_next;
          r_serial_out <= w_shifted_bit;
          r_count      <= r_count - LP_ONE;
          if (r_count == LP_ONE) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out        = r_out;
  assign bus.serial_out = r_serial_out;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random commands,
// compared against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  localparam logic [2:0] M_LOAD = 3'b000;
  localparam logic [2:0] M_SLL  = 3'b001;
  localparam logic [2:0] M_SRL  = 3'b010;
  localparam logic [2:0] M_ROL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_NOP  = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] m_val = '0;
  logic             m_so = 1'b0;
  logic [WIDTH-1:0] trace [0:63];

  univ_shift_reg_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: applies a whole command to m_val/m_so and returns the expected busy length.
  function automatic int model(input logic [2:0] m, input logic [AMT_W-1:0] a,
                               input logic [WIDTH-1:0] p, input logic [63:0] sin_pat);
    int n;
    logic s;
    n = (int'(a) > WIDTH) ? WIDTH : int'(a);
    case (m)
      M_LOAD: begin m_val = p; return 1; end
      M_CLR:  begin m_val = '0; return 1; end
      M_NOP:  return 1;
      default: begin
        for (int i = 0; i < n; i++) begin
          s = sin_pat[i];
          case (m)
            M_SLL: begin m_so = m_val[WIDTH-1]; m_val = (m_val << 1) | WIDTH'(s); end
            M_SRL: begin m_so = m_val[0]; m_val = (m_val >> 1) | (WIDTH'(s) << (WIDTH-1)); end
            M_ROL: begin m_so = m_val[WIDTH-1]; m_val = (m_val << 1) | (m_val >> (WIDTH-1)); end
            M_ROR: begin m_so = m_val[0]; m_val = (m_val >> 1) | (m_val << (WIDTH-1)); end
            default: begin m_so = m_val[0]; m_val = WIDTH'($signed(m_val) >>> 1); end
          endcase
        end
        return (n == 0) ? 1 : n + 1;
      end
    endcase
  endfunction

  // Issues one command from IDLE and observes it until busy drops; inj>=0 pulses a clear
  // command during that cycle of the operation, which must be ignored.
  task automatic run_cmd(input logic [2:0] m, input logic [AMT_W-1:0] a,
                         input logic [WIDTH-1:0] p, input logic [63:0] sin_pat, input int inj,
                         output int n_busy, output int done_cyc, output int n_done);
    int c;
    n_busy = 0; done_cyc = -1; n_done = 0;
    bus.start = 1'b1; bus.mode = m; bus.amount = a; bus.par_in = p; bus.serial_in = 1'b0;
    @(posedge clk); #1;
    bus.mode = 3'($urandom); bus.amount = AMT_W'($urandom); bus.par_in = WIDTH'($urandom);
    c = 0;
    forever begin
      bus.serial_in = sin_pat[c];
      bus.start = (c == inj);
      if (c == inj) bus.mode = M_CLR;
      @(negedge clk);
      trace[c] = bus.out;
      if (bus.done) begin n_done++; done_cyc = c; end
      if (!bus.busy) break;
      n_busy++;
      c++;
      if (c >= 64) begin
        n_tests++; n_fail++;
        $display("FAIL timeout: busy still %0b after %0d cycles, required low", bus.busy, c);
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'($urandom); bus.mode = 3'($urandom); bus.amount = AMT_W'($urandom);
      bus.par_in = WIDTH'($urandom); bus.serial_in = 1'($urandom);
      @(negedge clk);
      n_tests++; if (bus.out !== '0) begin n_fail++; $display("FAIL reset_out: got %h, required 0", bus.out); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", bus.done); end
      n_tests++; if (bus.serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b, required 0", bus.serial_out); end
    end
    bus.start = 1'b0;
    reset = 1'b0;
    m_val = '0; m_so = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_shift;
    int nb, dc, nd, eb;
    eb = model(M_LOAD, '0, 16'hA5F0, '0);
    run_cmd(M_LOAD, '0, 16'hA5F0, '0, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'hA5F0) begin n_fail++; $display("FAIL load_out: got %h, required a5f0", bus.out); end
    n_tests++; if (nb !== 1 || dc !== 0) begin n_fail++; $display("FAIL load_timing: busy %0d done@%0d, required 1 and 0", nb, dc); end
    eb = model(M_SLL, 5'd4, '0, {64{1'b1}});
    run_cmd(M_SLL, 5'd4, '0, {64{1'b1}}, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h5F0F) begin n_fail++; $display("FAIL sll4_out: got %h, required 5f0f", bus.out); end
    n_tests++; if (bus.serial_out !== 1'b0) begin n_fail++; $display("FAIL sll4_so: got %b, required 0", bus.serial_out); end
    n_tests++; if (nb !== 5 || dc !== 4 || nd !== 1) begin
      n_fail++; $display("FAIL sll4_timing: busy %0d done@%0d pulses %0d, required 5 4 1", nb, dc, nd);
    end
  endtask

  task automatic test_shift_right;
    int nb, dc, nd, eb;
    eb = model(M_LOAD, '0, 16'h8001, '0);
    run_cmd(M_LOAD, '0, 16'h8001, '0, -1, nb, dc, nd);
    eb = model(M_ASR, 5'd3, '0, '0);
    run_cmd(M_ASR, 5'd3, '0, {64{1'b1}}, -1, nb, dc, nd);
    n_tests++; if (trace[1] !== 16'hC000 || trace[2] !== 16'hE000 || trace[3] !== 16'hF000) begin
      n_fail++; $display("FAIL asr_steps: got %h %h %h, required c000 e000 f000", trace[1], trace[2], trace[3]);
    end
    n_tests++; if (bus.serial_out !== 1'b0) begin n_fail++; $display("FAIL asr_so: got %b, required 0", bus.serial_out); end
    eb = model(M_LOAD, '0, 16'h8001, '0);
    run_cmd(M_LOAD, '0, 16'h8001, '0, -1, nb, dc, nd);
    eb = model(M_SRL, 5'd1, '0, '0);
    run_cmd(M_SRL, 5'd1, '0, '0, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h4000 || bus.serial_out !== 1'b1) begin
      n_fail++; $display("FAIL srl1: got %h/%b, required 4000/1", bus.out, bus.serial_out);
    end
  endtask

  task automatic test_rotate;
    int nb, dc, nd, eb;
    eb = model(M_LOAD, '0, 16'h1234, '0);
    run_cmd(M_LOAD, '0, 16'h1234, '0, -1, nb, dc, nd);
    eb = model(M_ROR, 5'd16, '0, '0);
    run_cmd(M_ROR, 5'd16, '0, '0, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h1234 || nb !== 17 || dc !== 16) begin
      n_fail++; $display("FAIL ror16: got %h busy %0d done@%0d, required 1234 17 16", bus.out, nb, dc);
    end
    n_tests++; if (bus.serial_out !== m_so) begin n_fail++; $display("FAIL ror16_so: got %b, required %b", bus.serial_out, m_so); end
    eb = model(M_ROR, 5'd20, '0, '0);
    run_cmd(M_ROR, 5'd20, '0, '0, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h1234 || nb !== 17 || dc !== 16) begin
      n_fail++; $display("FAIL ror20_clamp: got %h busy %0d done@%0d, required 1234 17 16", bus.out, nb, dc);
    end
    eb = model(M_ROL, 5'd4, '0, '0);
    run_cmd(M_ROL, 5'd4, '0, '0, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h2341) begin n_fail++; $display("FAIL rol4: got %h, required 2341", bus.out); end
  endtask

  task automatic test_zero_and_ignore;
    int nb, dc, nd, eb;
    logic [63:0] pat;
    eb = model(M_SLL, 5'd0, '0, '0);
    run_cmd(M_SLL, 5'd0, '0, {64{1'b1}}, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h2341 || nb !== 1 || dc !== 0) begin
      n_fail++; $display("FAIL amt0: got %h busy %0d done@%0d, required 2341 1 0", bus.out, nb, dc);
    end
    pat = {$urandom, $urandom};
    eb = model(M_SLL, 5'd8, '0, pat);
    run_cmd(M_SLL, 5'd8, '0, pat, 3, nb, dc, nd);
    n_tests++; if (bus.out !== m_val || bus.serial_out !== m_so) begin
      n_fail++; $display("FAIL ignore_start: got %h/%b, required %h/%b", bus.out, bus.serial_out, m_val, m_so);
    end
    n_tests++; if (nb !== eb || nd !== 1) begin
      n_fail++; $display("FAIL ignore_timing: busy %0d pulses %0d, required %0d 1", nb, nd, eb);
    end
  endtask

  task automatic test_serial_toggle;
    int nb, dc, nd, eb;
    eb = model(M_LOAD, '0, 16'hFFFF, '0);
    run_cmd(M_LOAD, '0, 16'hFFFF, '0, -1, nb, dc, nd);
    eb = model(M_SRL, 5'd4, '0, 64'h5);
    run_cmd(M_SRL, 5'd4, '0, 64'h5, -1, nb, dc, nd);
    n_tests++; if (bus.out !== 16'h5FFF) begin n_fail++; $display("FAIL srl_toggle: got %h, required 5fff", bus.out); end
  endtask

  task automatic test_back_to_back;
    int eb;
    bus.start = 1'b1; bus.mode = M_LOAD; bus.par_in = 16'hBEEF;
    @(posedge clk); #1;
    bus.par_in = 16'hC0DE;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b1 || bus.out !== 16'hBEEF) begin
      n_fail++; $display("FAIL b2b_first: got busy %b done %b out %h, required 1 1 beef", bus.busy, bus.done, bus.out);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'hBEEF) begin
      n_fail++; $display("FAIL b2b_gap: got busy %b done %b out %h, required 0 0 beef", bus.busy, bus.done, bus.out);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b1 || bus.out !== 16'hC0DE) begin
      n_fail++; $display("FAIL b2b_second: got busy %b done %b out %h, required 1 1 c0de", bus.busy, bus.done, bus.out);
    end
    eb = model(M_LOAD, '0, 16'hC0DE, '0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift;
    int nb, dc, nd, eb;
    logic saw_done;
    eb = model(M_LOAD, '0, 16'hFFFF, '0);
    run_cmd(M_LOAD, '0, 16'hFFFF, '0, -1, nb, dc, nd);
    bus.start = 1'b1; bus.mode = M_SLL; bus.amount = 5'd8; bus.serial_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || bus.out !== 16'hFFFC) begin
      n_fail++; $display("FAIL pre_abort: got busy %b out %h, required 1 fffc", bus.busy, bus.out);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++; if (bus.out !== '0 || bus.serial_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got out %h so %b busy %b done %b, required all 0",
                         bus.out, bus.serial_out, bus.busy, bus.done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_done |= bus.done; end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); saw_done |= bus.done | bus.busy; end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity %b, required 0", saw_done); end
    m_val = '0; m_so = 1'b0;
  endtask

  task automatic test_random;
    int nb, dc, nd, eb;
    logic [2:0] m;
    logic [AMT_W-1:0] a;
    logic [WIDTH-1:0] p;
    logic [63:0] pat;
    for (int t = 0; t < 40; t++) begin
      m = 3'($urandom); a = AMT_W'($urandom); p = WIDTH'($urandom); pat = {$urandom, $urandom};
      if (t % 8 == 0) m = M_LOAD;
      eb = model(m, a, p, pat);
      run_cmd(m, a, p, pat, -1, nb, dc, nd);
      n_tests++; if (bus.out !== m_val) begin
        n_fail++; $display("FAIL rnd_out[%0d] mode %0d amt %0d: got %h, required %h", t, m, a, bus.out, m_val);
      end
      n_tests++; if (bus.serial_out !== m_so) begin
        n_fail++; $display("FAIL rnd_so[%0d] mode %0d amt %0d: got %b, required %b", t, m, a, bus.serial_out, m_so);
      end
      n_tests++; if (nb !== eb || dc !== eb - 1 || nd !== 1) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: busy %0d done@%0d pulses %0d, required %0d %0d 1", t, nb, dc, nd, eb, eb - 1);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = M_NOP; bus.amount = '0; bus.par_in = '0; bus.serial_in = 1'b0;
    test_reset;
    test_load_shift;
    test_shift_right;
    test_rotate;
    test_zero_and_ignore;
    test_serial_toggle;
    test_back_to_back;
    test_reset_mid_shift;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
